// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte streams share one uart_tx.
// Define UART_ARB_HEADER_EN to send an 8'hA0|g header byte at the start of each grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef UART_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE, HDR, LOAD, SEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

  state_t                 state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          owner;
  logic                   held_last;
  logic [BW-1:0]          burst_cnt;
  logic [TW-1:0]          idle_cnt;

  logic                   pick_found;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          cand;
  logic [PW-1:0]          next_ptr;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Circular search for the first valid requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign next_ptr  = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign sel_data  = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign req_ready = (ena && state == LOAD) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      held_last <= 1'b0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant     <= NUM_REQ'(1) << pick_idx;
            owner     <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
`ifdef UART_ARB_HEADER_EN
            tx_data   <= DATA_WIDTH'(8'hA0) | DATA_WIDTH'(pick_idx);
            tx_valid  <= 1'b1;
            state     <= HDR;
`else
            state     <= LOAD;
`endif
          end
        end
`ifdef UART_ARB_HEADER_EN
        HDR: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= LOAD;
          end
        end
`endif
        LOAD: begin
          // req_ready is high here, so a valid byte is an accepted byte
          if (req_valid[owner]) begin
            tx_data   <= sel_data;
            held_last <= req_last[owner];
            tx_valid  <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
            state     <= SEND;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            idle_cnt <= '0;
            grant    <= '0;
            rr_ptr   <= next_ptr;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (held_last || burst_cnt == BW'(MAX_BURST)) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL be the number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL be the byte width, matching uart_tx.
REQ-003 Parameter TIMEOUT, default 16, SHALL be the number of idle enabled cycles after which a stalled grant is revoked.
REQ-004 Parameter MAX_BURST, default 16, SHALL be the maximum bytes forwarded per grant.
REQ-005 clk  input  1  SHALL be the clock.
REQ-006 reset_n  input  1  SHALL be the reset, synchronous, active-low.
REQ-007 ena  input  1  SHALL be the clock enable; state advances only when 1.
REQ-008 req_valid  input  NUM_REQ  SHALL be the per-requester byte-valid signals.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  SHALL be the per-requester bytes; requester i occupies slice i.
REQ-010 req_last  input  NUM_REQ  SHALL mark the final byte of a packet.
REQ-011 req_ready  output  NUM_REQ  SHALL be the per-requester byte-accept signals.
REQ-012 grant  output  NUM_REQ  SHALL be the one-hot current owner, or zero when idle.
REQ-013 tx_data  output  DATA_WIDTH  SHALL be the byte to uart_tx.
REQ-014 tx_valid  output  1  SHALL be the valid to uart_tx.
REQ-015 tx_ready  input  1  SHALL be the ready from uart_tx.
REQ-016 busy  output  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-017 States SHALL be IDLE, HDR, LOAD and SEND.
REQ-018 Transfers: a requester byte transfers on ena & req_valid[g] & req_ready[g]; a uart byte transfers on ena & tx_valid & tx_ready.
REQ-019 IDLE, any req_valid set: grant SHALL register next cycle to the first set bit at or after rr_ptr, circularly; the state goes to HDR (macro defined) or LOAD.
REQ-020 LOAD: req_ready[g] SHALL equal the LOAD-state flag, unregistered; on transfer the data and last flag are captured, the state goes to SEND and tx_valid registers 1.
REQ-021 SEND: tx_data and tx_valid SHALL be held stable until the uart transfer, after which tx_valid goes 0 the next cycle.
REQ-022 SEND, after the uart transfer: if last=1 or the burst count reaches MAX_BURST, the state goes to IDLE, grant clears and rr_ptr becomes g+1 mod NUM_REQ; otherwise the state goes to LOAD.
REQ-023 Latency: a req_valid at cycle t in IDLE (no header) SHALL give grant at t+1, capture at t+1 and tx_valid at t+2.
REQ-024 LOAD timeout: a TIMEOUT-cycle counter SHALL run while req_valid[g]=0; at expiry the state goes to IDLE and rr_ptr advances.
REQ-025 The timeout counter SHALL reset on every requester transfer.
REQ-026 The burst counter SHALL be $clog2(MAX_BURST)+1 bits wide and clear at each new grant.
REQ-027 req_ready SHALL be 0 for all non-granted requesters, and for all requesters while ena=0.
REQ-028 ena=0 SHALL freeze all registers and counters.
REQ-029 Simultaneous requests SHALL be resolved by rr_ptr only; a requester whose valid drops while waiting SHALL lose no state.
REQ-030 At most one tx_valid pulse SHALL be issued per captured byte; no byte is duplicated or dropped.

Reset
REQ-031 On reset_n=0 at a clk edge: state IDLE, grant=0, rr_ptr=0, tx_valid=0, tx_data=0, busy=0, counters=0.
REQ-032 A reset mid-packet SHALL discard any held byte, with no tx_valid on the following cycle.

Configuration
REQ-033 With UART_ARB_HEADER_EN defined, HDR SHALL be entered after each grant and SHALL send the byte 8'hA0 | g as a uart transfer before LOAD; the header is not counted in the burst.
REQ-034 Without UART_ARB_HEADER_EN, the HDR state and its logic SHALL be absent, and IDLE goes directly to LOAD.

Verification
REQ-035 Single requester: req 0 sends 8'h55 with last=1 and tx_ready=1 -> tx_valid at t+2 with tx_data=8'h55, then IDLE with rr_ptr=1.
REQ-036 Contention: req 0..3 all valid with one byte each, last=1 -> uart order 0,1,2,3, then 0 again on re-request.
REQ-037 Burst limit: req 2 streams 20 bytes without last -> 16 bytes sent, grant released, 4 remaining bytes sent after re-arbitration.
REQ-038 Timeout: req 1 granted, then valid held 0 -> state returns to IDLE after 16 cycles and req 3 is granted next.
REQ-039 Backpressure and ena: tx_ready=0 for 50 cycles with ena toggling -> tx_data stable, exactly one transfer, req_ready=0 while ena=0.
REQ-040 Header (macro defined): req 3 sends 8'h12 -> uart sees 8'hA3 then 8'h12; reset asserted mid-SEND -> tx_valid=0 the next cycle.
